// File: rtl/global_position_integrator_pkg.sv
// Shared types and constants for the global pose integrator: FSM encoding,
// fixed-point limits and the default sample-period coefficients.
package global_position_integrator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_X,
    ST_MUL_Y,
    ST_MUL_T,
    ST_ACCUM,
    ST_WRAP,
    ST_DONE
  } state_t;

  localparam int unsigned THETA_FULL_Q15   = 32'd11796480;
  localparam int unsigned SM_MAX           = 32'h7FFF_FFFF;
  localparam int          DT_Q_DEFAULT     = 328;
  localparam int          DT_DEG_Q_DEFAULT = 18775;

endpackage

// File: rtl/global_position_integrator_seq_qmult_sm.sv
// Sign-magnitude shift-add Q multiplier: N_WIDTH cycles from start to done, operands held by caller;
// a new start (or flush) always wins over an operation in flight.
module global_position_integrator_seq_qmult_sm #(
  parameter int N_WIDTH = 32,
  parameter int Q_WIDTH = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               start_i,
  input  logic [N_WIDTH-1:0] a_i,
  input  logic [N_WIDTH-1:0] b_i,
  output logic               done_o,
  output logic [N_WIDTH-1:0] p_o
);

  localparam int PW = 2 * (N_WIDTH - 1);
  localparam int CW = $clog2(N_WIDTH);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] bit_idx;
  logic [PW-1:0] addend;
  logic [PW-1:0] shifted;
  logic          sat;
  logic [N_WIDTH-2:0] mag;
  logic          last;

  // MSB-first over the magnitude bits; the final count is a settle cycle that presents the result.
  assign last    = (cnt_q == CW'(N_WIDTH - 1));
  assign bit_idx = CW'(N_WIDTH - 2) - cnt_q;
  assign addend  = b_i[bit_idx] ? {{(PW-N_WIDTH+1){1'b0}}, a_i[N_WIDTH-2:0]} : '0;
  assign acc_d   = {acc_q[PW-2:0], 1'b0} + addend;

  assign shifted = acc_q >> Q_WIDTH;
  assign sat     = |shifted[PW-1:N_WIDTH-1];
  assign mag     = sat ? {(N_WIDTH-1){1'b1}} : shifted[N_WIDTH-2:0];
  assign p_o     = {(a_i[N_WIDTH-1] ^ b_i[N_WIDTH-1]) & (|mag), mag};
  assign done_o  = busy_q & last;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (busy_q) begin
      if (last) begin
        busy_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/global_position_integrator.sv
// Integrates global vx/vy/wz over one sample into pose x, y, theta; DONE 99 cycles after READY is taken.
// READY is only accepted in IDLE (never queued); CLEAR aborts a step and zeroes the pose.
module global_position_integrator
  import global_position_integrator_pkg::*;
#(
  parameter int N_WIDTH  = 32,
  parameter int Q_WIDTH  = 15,
  parameter int DT_Q     = DT_Q_DEFAULT,
  parameter int DT_DEG_Q = DT_DEG_Q_DEFAULT
) (
  input  logic               GLOBAL_POSITION_CLOCK_50,
  input  logic               GLOBAL_POSITION_RESET_InHigh,
  input  logic               GLOBAL_POSITION_READY_In,
  input  logic               GLOBAL_POSITION_CLEAR_In,
  input  logic [N_WIDTH-1:0] GLOBAL_POSITION_VX_InBus,
  input  logic [N_WIDTH-1:0] GLOBAL_POSITION_VY_InBus,
  input  logic [N_WIDTH-1:0] GLOBAL_POSITION_WZ_InBus,
  output logic               GLOBAL_POSITION_DONE_Out,
  output logic               GLOBAL_POSITION_BUSY_Out,
  output logic [N_WIDTH-1:0] GLOBAL_POSITION_X_OutBus,
  output logic [N_WIDTH-1:0] GLOBAL_POSITION_Y_OutBus,
  output logic [N_WIDTH-1:0] GLOBAL_POSITION_THETA_OutBus,
  output logic               GLOBAL_POSITION_OVERFLOW_Out
);

  localparam logic signed [N_WIDTH:0] MAX_S  = (N_WIDTH+1)'(SM_MAX);
  localparam logic signed [N_WIDTH:0] FULL_S = (N_WIDTH+1)'(THETA_FULL_Q15);

  state_t state_q, state_d;
  logic [N_WIDTH-1:0] vx_q, vy_q, wz_q, dx_q, dy_q, dth_q;
  logic [N_WIDTH-1:0] x_q, y_q, th_q, x_acc_q, y_acc_q;
  logic signed [N_WIDTH:0] th_acc_q, th_wrap, x_sum, y_sum;
  logic [N_WIDTH:0] x_res, y_res;
  logic ovf_q, ovf_acc_q;
  logic mul_start, mul_done;
  logic [N_WIDTH-1:0] mul_a, mul_b, mul_p;
  logic th_wrap_unused;

  function automatic logic signed [N_WIDTH:0] sm_to_tc(input logic [N_WIDTH-1:0] v);
    logic signed [N_WIDTH:0] m;
    m = {2'b00, v[N_WIDTH-2:0]};
    return v[N_WIDTH-1] ? -m : m;
  endfunction

  // Returns {saturated, sign-magnitude}; a zero result always carries a positive sign.
  function automatic logic [N_WIDTH:0] tc_to_sm_sat(input logic signed [N_WIDTH:0] s);
    logic signed [N_WIDTH:0] m;
    logic [N_WIDTH:0] r;
    m = s[N_WIDTH] ? -s : s;
    if (s > MAX_S || s < -MAX_S) r = {1'b1, s[N_WIDTH], {(N_WIDTH-1){1'b1}}};
    else                         r = {1'b0, s[N_WIDTH], m[N_WIDTH-2:0]};
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (GLOBAL_POSITION_READY_In) begin state_d = ST_MUL_X; mul_start = 1'b1; end
      ST_MUL_X: if (mul_done) begin state_d = ST_MUL_Y; mul_start = 1'b1; end
      ST_MUL_Y: if (mul_done) begin state_d = ST_MUL_T; mul_start = 1'b1; end
      ST_MUL_T: if (mul_done) state_d = ST_ACCUM;
      ST_ACCUM: state_d = ST_WRAP;
      ST_WRAP:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign mul_a = (state_q == ST_MUL_Y) ? vy_q : (state_q == ST_MUL_T) ? wz_q : vx_q;
  assign mul_b = (state_q == ST_MUL_T) ? N_WIDTH'(DT_DEG_Q) : N_WIDTH'(DT_Q);

  global_position_integrator_seq_qmult_sm #(.N_WIDTH(N_WIDTH), .Q_WIDTH(Q_WIDTH)) u_seq_qmult_sm (
    .clk_i   (GLOBAL_POSITION_CLOCK_50),
    .rst_i   (GLOBAL_POSITION_RESET_InHigh),
    .flush_i (GLOBAL_POSITION_CLEAR_In),
    .start_i (mul_start),
    .a_i     (mul_a),
    .b_i     (mul_b),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  assign x_sum = sm_to_tc(x_q) + sm_to_tc(dx_q);
  assign y_sum = sm_to_tc(y_q) + sm_to_tc(dy_q);
  assign x_res = tc_to_sm_sat(x_sum);
  assign y_res = tc_to_sm_sat(y_sum);

  // One correction suffices because a single step never turns more than a full circle.
  always_comb begin
    th_wrap = th_acc_q;
    if (th_acc_q >= FULL_S)    th_wrap = th_acc_q - FULL_S;
    else if (th_acc_q[N_WIDTH]) th_wrap = th_acc_q + FULL_S;
  end
  assign th_wrap_unused = th_wrap[N_WIDTH];

  always_ff @(posedge GLOBAL_POSITION_CLOCK_50) begin
    if (GLOBAL_POSITION_RESET_InHigh || GLOBAL_POSITION_CLEAR_In) begin
      state_q   <= ST_IDLE;
      {vx_q, vy_q, wz_q}     <= '0;
      {dx_q, dy_q, dth_q}    <= '0;
      {x_acc_q, y_acc_q}     <= '0;
      th_acc_q  <= '0;
      ovf_acc_q <= 1'b0;
      {x_q, y_q, th_q}       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && GLOBAL_POSITION_READY_In) begin
        vx_q <= GLOBAL_POSITION_VX_InBus;
        vy_q <= GLOBAL_POSITION_VY_InBus;
        wz_q <= GLOBAL_POSITION_WZ_InBus;
      end
      if (mul_done && state_q == ST_MUL_X) dx_q  <= mul_p;
      if (mul_done && state_q == ST_MUL_Y) dy_q  <= mul_p;
      if (mul_done && state_q == ST_MUL_T) dth_q <= mul_p;
      if (state_q == ST_ACCUM) begin
        x_acc_q   <= x_res[N_WIDTH-1:0];
        y_acc_q   <= y_res[N_WIDTH-1:0];
        ovf_acc_q <= ovf_q | x_res[N_WIDTH] | y_res[N_WIDTH];
        th_acc_q  <= sm_to_tc(th_q) + sm_to_tc(dth_q);
      end
      if (state_q == ST_WRAP) begin
        x_q   <= x_acc_q;
        y_q   <= y_acc_q;
        th_q  <= th_wrap[N_WIDTH-1:0];
        ovf_q <= ovf_acc_q;
      end
    end
  end

  assign GLOBAL_POSITION_DONE_Out     = (state_q == ST_DONE);
  assign GLOBAL_POSITION_BUSY_Out     = (state_q != ST_IDLE);
  assign GLOBAL_POSITION_X_OutBus     = x_q;
  assign GLOBAL_POSITION_Y_OutBus     = y_q;
  assign GLOBAL_POSITION_THETA_OutBus = th_q;
  assign GLOBAL_POSITION_OVERFLOW_Out = ovf_q;

endmodule

// File: tb/tb_global_position_integrator.sv
// Bench for the pose integrator: directed scenarios plus random steps against an arithmetic pose model,
// run on a default instance and a dt=1.0 s instance sharing the same stimulus.
module tb_global_position_integrator;

  localparam longint MAXV = 64'h7FFF_FFFF;
  localparam longint FULL = 64'd11796480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ready, clear;
  logic [31:0] vx, vy, wz;
  logic done0, busy0, ovf0, done1, busy1, ovf1;
  logic [31:0] x0, y0, th0, x1, y1, th1;

  int n_cmp = 0;
  int n_mis = 0;

  longint mx[2], my[2], mth[2];
  bit     movf[2];
  longint dtq[2] = '{64'd328, 64'd32768};

  global_position_integrator u_dut (
    .GLOBAL_POSITION_CLOCK_50(clk), .GLOBAL_POSITION_RESET_InHigh(rst),
    .GLOBAL_POSITION_READY_In(ready), .GLOBAL_POSITION_CLEAR_In(clear),
    .GLOBAL_POSITION_VX_InBus(vx), .GLOBAL_POSITION_VY_InBus(vy), .GLOBAL_POSITION_WZ_InBus(wz),
    .GLOBAL_POSITION_DONE_Out(done0), .GLOBAL_POSITION_BUSY_Out(busy0),
    .GLOBAL_POSITION_X_OutBus(x0), .GLOBAL_POSITION_Y_OutBus(y0),
    .GLOBAL_POSITION_THETA_OutBus(th0), .GLOBAL_POSITION_OVERFLOW_Out(ovf0));

  global_position_integrator #(.DT_Q(32768)) u_dut_dt1 (
    .GLOBAL_POSITION_CLOCK_50(clk), .GLOBAL_POSITION_RESET_InHigh(rst),
    .GLOBAL_POSITION_READY_In(ready), .GLOBAL_POSITION_CLEAR_In(clear),
    .GLOBAL_POSITION_VX_InBus(vx), .GLOBAL_POSITION_VY_InBus(vy), .GLOBAL_POSITION_WZ_InBus(wz),
    .GLOBAL_POSITION_DONE_Out(done1), .GLOBAL_POSITION_BUSY_Out(busy1),
    .GLOBAL_POSITION_X_OutBus(x1), .GLOBAL_POSITION_Y_OutBus(y1),
    .GLOBAL_POSITION_THETA_OutBus(th1), .GLOBAL_POSITION_OVERFLOW_Out(ovf1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sm2i(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] i2sm(input longint v);
    logic [31:0] r;
    if (v < 0) begin r = 32'(-v); r[31] = 1'b1; end
    else r = 32'(v);
    return r;
  endfunction

  function automatic longint qmul(input logic [31:0] a, input longint c);
    longint m;
    m = (longint'(a[30:0]) * c) >>> 15;
    if (m > MAXV) m = MAXV;
    return a[31] ? -m : m;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 2; i++) begin mx[i] = 0; my[i] = 0; mth[i] = 0; movf[i] = 1'b0; end
  endtask

  task automatic model_step(input logic [31:0] ax, input logic [31:0] ay, input logic [31:0] az);
    for (int i = 0; i < 2; i++) begin
      mx[i] = mx[i] + qmul(ax, dtq[i]);
      my[i] = my[i] + qmul(ay, dtq[i]);
      if (mx[i] > MAXV) begin mx[i] = MAXV;  movf[i] = 1'b1; end
      if (mx[i] < -MAXV) begin mx[i] = -MAXV; movf[i] = 1'b1; end
      if (my[i] > MAXV) begin my[i] = MAXV;  movf[i] = 1'b1; end
      if (my[i] < -MAXV) begin my[i] = -MAXV; movf[i] = 1'b1; end
      mth[i] = mth[i] + qmul(az, 64'd18775);
      if (mth[i] >= FULL) mth[i] = mth[i] - FULL;
      else if (mth[i] < 0) mth[i] = mth[i] + FULL;
    end
  endtask

  task automatic check_pose(input string tag);
    check({tag, "_x0"},  x0,  i2sm(mx[0]));
    check({tag, "_y0"},  y0,  i2sm(my[0]));
    check({tag, "_th0"}, th0, i2sm(mth[0]));
    check({tag, "_ov0"}, {31'd0, ovf0}, {31'd0, movf[0]});
    check({tag, "_x1"},  x1,  i2sm(mx[1]));
    check({tag, "_y1"},  y1,  i2sm(my[1]));
    check({tag, "_th1"}, th1, i2sm(mth[1]));
    check({tag, "_ov1"}, {31'd0, ovf1}, {31'd0, movf[1]});
  endtask

  task automatic clear_pose();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_zero();
  endtask

  // Starts one step, waits (bounded) for DONE, checks pose held until DONE, then the new pose.
  task automatic do_step(input string tag, input logic [31:0] ax, input logic [31:0] ay,
                         input logic [31:0] az, output int lat, output int busy_pre);
    logic [31:0] xb;
    vx = ax; vy = ay; wz = az; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    vx = $urandom; vy = $urandom;
    lat = 1; busy_pre = 0; xb = x0;
    while (!done0 && lat < 200) begin
      if (busy0) busy_pre++;
      xb = x0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done"}, {31'd0, done0}, 32'd1);
    check({tag, "_done1"}, {31'd0, done1}, 32'd1);
    check({tag, "_hold"}, xb, i2sm(mx[0]));
    model_step(ax, ay, az);
    check_pose(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, bp, ndone, cyc, last, per_bad, dcyc;
    logic [31:0] rx, ry, rz;
    rst = 1'b1; ready = 1'b0; clear = 1'b0; vx = '0; vy = '0; wz = '0;
    model_zero();
    repeat (3) @(posedge clk); #1;
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check_pose("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1 m/s for one step
    do_step("t1", 32'd32768, 32'd0, 32'd0, lat, bp);
    check("t1_lat", 32'(lat), 32'd99);
    check("t1_busy", 32'(bp), 32'd98);
    check("t1_x", x0, 32'd328);
    check("t1_idle", {31'd0, busy0}, 32'd0);

    // 100 back-to-back steps with READY held high
    clear_pose();
    vx = 32'd32768; vy = '0; wz = '0; ready = 1'b1;
    ndone = 0; cyc = 0; last = 0; per_bad = 0;
    while (ndone < 100 && cyc < 10500) begin
      @(posedge clk); #1;
      cyc++;
      if (done0) begin
        model_step(32'd32768, 32'd0, 32'd0);
        ndone++;
        if (ndone > 1 && cyc - last != 100) per_bad++;
        last = cyc;
        if (ndone == 100) ready = 1'b0;
      end
    end
    ready = 1'b0;
    check("t2_ndone", 32'(ndone), 32'd100);
    check("t2_period_errs", 32'(per_bad), 32'd0);
    check("t2_x", x0, 32'd32800);
    check_pose("t2");
    @(posedge clk); #1;
    check("t2_idle", {31'd0, busy0}, 32'd0);

    // negative y then back to zero without -0
    clear_pose();
    do_step("t3a", 32'd0, 32'h8000_8000, 32'd0, lat, bp);
    check("t3_yneg", y0, 32'h8000_0148);
    do_step("t3b", 32'd0, 32'h0000_8000, 32'd0, lat, bp);
    check("t3_yzero", y0, 32'h0000_0000);

    // heading wrap in both directions
    clear_pose();
    for (int i = 0; i < 6; i++) do_step("t4", 32'd0, 32'd0, 32'd3276800, lat, bp);
    check("t4_th6", th0, 32'd11265000);
    do_step("t4", 32'd0, 32'd0, 32'd3276800, lat, bp);
    check("t4_th7", th0, 32'd1346020);
    clear_pose();
    do_step("t4n", 32'd0, 32'd0, 32'h8000_8000, lat, bp);
    check("t4_thneg", th0, 32'd11777705);

    // saturation and sticky overflow on the dt=1 s instance
    clear_pose();
    do_step("t5a", 32'h7FFF_FFFF, 32'd0, 32'd0, lat, bp);
    check("t5_x1a", x1, 32'h7FFF_FFFF);
    check("t5_ov1a", {31'd0, ovf1}, 32'd0);
    do_step("t5b", 32'h7FFF_FFFF, 32'd0, 32'd0, lat, bp);
    check("t5_x1b", x1, 32'h7FFF_FFFF);
    check("t5_ov1b", {31'd0, ovf1}, 32'd1);
    do_step("t5c", 32'd0, 32'd0, 32'd0, lat, bp);
    check("t5_ov1c", {31'd0, ovf1}, 32'd1);

    // random steps
    clear_pose();
    for (int i = 0; i < 25; i++) begin
      rx = $urandom;
      ry = (i % 3 == 0) ? $urandom : {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 4000000))};
      rz = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 20000000))};
      do_step("rnd", rx, ry, rz, lat, bp);
    end

    // READY pulses mid-step ignored, input changes after capture ignored
    rx = 32'd65536; ry = 32'h8001_0000; rz = 32'd100000;
    vx = rx; vy = ry; wz = rz; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    ndone = 0; dcyc = 0;
    for (int c = 1; c <= 250; c++) begin
      if (done0) begin ndone++; dcyc = c; end
      if (c == 5) begin vx = $urandom; vy = $urandom; wz = $urandom_range(0, 1000); end
      ready = (c == 10 || c == 50);
      @(posedge clk); #1;
    end
    model_step(rx, ry, rz);
    check("t6_ndone", 32'(ndone), 32'd1);
    check("t6_dcyc", 32'(dcyc), 32'd99);
    check_pose("t6a");

    // CLEAR at cycle 40 aborts the step
    vx = 32'd32768; vy = 32'd32768; wz = 32'd32768; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    for (int c = 1; c < 40; c++) begin @(posedge clk); #1; end
    check("t6_busy40", {31'd0, busy0}, 32'd1);
    clear_pose();
    check("t6_clr_busy", {31'd0, busy0}, 32'd0);
    check_pose("t6b");
    ndone = 0;
    for (int c = 0; c < 150; c++) begin
      if (done0 || done1) ndone++;
      @(posedge clk); #1;
    end
    check("t6_clr_nodone", 32'(ndone), 32'd0);

    // CLEAR and READY together: CLEAR wins
    ready = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; clear = 1'b0;
    check("t6_clrrdy_busy", {31'd0, busy0}, 32'd0);

    // reset at cycle 60 mid-step
    do_step("t6c", 32'd98304, 32'd16384, 32'd65536, lat, bp);
    vx = 32'd32768; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    for (int c = 1; c < 60; c++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_zero();
    check("t6_rst_busy", {31'd0, busy0}, 32'd0);
    check("t6_rst_done", {31'd0, done0}, 32'd0);
    check_pose("t6r");
    do_step("post", 32'd32768, 32'd0, 32'd0, lat, bp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
